// File: rtl/iir_pkg.sv
// Shared sizing and saturation helpers for the IIR output decimator.
// Width functions take the instance parameters; defaults mirror the filter build.
package iir_pkg;

  localparam int DEFAULT_FIFO_DEPTH = 4;
  localparam int FIFO_LEVEL_W       = $clog2(DEFAULT_FIFO_DEPTH) + 1;

  function automatic int nb_acc(input int nb_data_in, input int decim_factor);
    return nb_data_in + $clog2(decim_factor);
  endfunction

  function automatic int fifo_level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int sat_max(input int nb_out);
    return (1 <<< (nb_out - 1)) - 1;
  endfunction

  function automatic int sat_min(input int nb_out);
    return -(1 <<< (nb_out - 1));
  endfunction

  // Clamp to the nb_out-bit signed range; the caller keeps the low nb_out bits.
  function automatic logic signed [31:0] saturate(input  logic signed [31:0] val,
                                                  input  int                 nb_out,
                                                  output logic               sat);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi  = sat_max(nb_out);
    lo  = sat_min(nb_out);
    sat = 1'b0;
    if (val > hi) begin
      sat = 1'b1;
      return hi;
    end
    if (val < lo) begin
      sat = 1'b1;
      return lo;
    end
    return val;
  endfunction

endpackage

// File: rtl/iir_sample_fifo.sv
// Synchronous sample FIFO with wrap pointers and occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module iir_sample_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (level == (AW + 1)'(DEPTH));
  assign empty = (level == '0);
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign rdata = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !clear) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/iir_output_decimator.sv
// Boxcar accumulate-and-dump decimator with saturation, output FIFO and sticky flags.
// The dump sum is formed combinationally so the result lands in the FIFO on the same edge.
module iir_output_decimator
  import iir_pkg::*;
#(
  parameter int NB_DATA_IN   = 11,
  parameter int NB_DATA_OUT  = 8,
  parameter int DECIM_FACTOR = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                                  i_clock,
  input  logic                                  i_reset_n,
  input  logic signed [NB_DATA_IN-1:0]          i_data,
  input  logic                                  i_valid,
  input  logic                                  i_clear,
  input  logic                                  i_ready,
  output logic signed [NB_DATA_OUT-1:0]         o_data,
  output logic                                  o_valid,
  output logic [fifo_level_w(FIFO_DEPTH)-1:0]   o_level,
  output logic                                  o_sat,
  output logic                                  o_overflow
);

  localparam int NB_ACC = nb_acc(NB_DATA_IN, DECIM_FACTOR);
  localparam int SHIFT  = $clog2(DECIM_FACTOR);

  logic signed [NB_ACC-1:0]      acc;
  logic signed [NB_ACC-1:0]      sum;
  logic signed [NB_ACC-1:0]      avg;
  logic signed [31:0]            sat_wide;
  logic signed [NB_DATA_OUT-1:0] result;
  logic                          sat_hit;
  logic [SHIFT-1:0]              phase;
  logic                          dump;
  logic                          pop;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic                          overflow_evt;
  logic [NB_DATA_OUT-1:0]        fifo_rdata;

  assign dump         = i_valid && (phase == SHIFT'(DECIM_FACTOR - 1));
  assign pop          = o_valid && i_ready;
  assign overflow_evt = dump && fifo_full && !pop;

  always_comb begin
    sum      = acc + NB_ACC'(i_data);
    avg      = sum >>> SHIFT;
    sat_hit  = 1'b0;
    sat_wide = saturate(32'(avg), NB_DATA_OUT, sat_hit);
    result   = sat_wide[NB_DATA_OUT-1:0];
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      acc        <= '0;
      phase      <= '0;
      o_sat      <= 1'b0;
      o_overflow <= 1'b0;
    end else if (i_clear) begin
      acc        <= '0;
      phase      <= '0;
      o_sat      <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      if (dump) begin
        acc   <= '0;
        phase <= '0;
      end else if (i_valid) begin
        acc   <= sum;
        phase <= phase + 1'b1;
      end
      if (dump && sat_hit) o_sat <= 1'b1;
      if (overflow_evt)    o_overflow <= 1'b1;
    end
  end

  iir_sample_fifo #(
    .WIDTH (NB_DATA_OUT),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clock),
    .rst_n (i_reset_n),
    .clear (i_clear),
    .push  (dump),
    .pop   (pop),
    .wdata (result),
    .rdata (fifo_rdata),
    .level (o_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign o_valid = !fifo_empty;
  assign o_data  = fifo_rdata;

endmodule

// File: tb/tb_iir_output_decimator.sv
// Directed and random stimulus for iir_output_decimator against a queue-based model.
// Inputs change and outputs are checked on the falling clock edge.
module tb_iir_output_decimator;

  localparam int NB_IN  = 11;
  localparam int NB_OUT = 8;
  localparam int DECIM  = 4;
  localparam int DEPTH  = 4;

  logic                     i_clock = 1'b0;
  logic                     i_reset_n;
  logic signed [NB_IN-1:0]  i_data;
  logic                     i_valid;
  logic                     i_clear;
  logic                     i_ready;
  logic signed [NB_OUT-1:0] o_data;
  logic                     o_valid;
  logic [2:0]               o_level;
  logic                     o_sat;
  logic                     o_overflow;

  int errors = 0;
  int checks = 0;

  int m_samp[$];
  int m_fifo[$];
  bit m_sat;
  bit m_ovf;

  always #5 i_clock = ~i_clock;

  iir_output_decimator #(
    .NB_DATA_IN   (NB_IN),
    .NB_DATA_OUT  (NB_OUT),
    .DECIM_FACTOR (DECIM),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .i_clock    (i_clock),
    .i_reset_n  (i_reset_n),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .i_clear    (i_clear),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_level    (o_level),
    .o_sat      (o_sat),
    .o_overflow (o_overflow)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_samp.delete();
    m_fifo.delete();
    m_sat = 1'b0;
    m_ovf = 1'b0;
  endtask

  // Average of DECIM samples with floor rounding, clamped to the output range.
  task automatic model_step(input bit v, input int d, input bit r, input bit c);
    bit pop;
    bit push;
    int s;
    int q;
    push = 1'b0;
    q    = 0;
    if (c) begin
      model_reset();
      return;
    end
    pop = (m_fifo.size() > 0) && r;
    if (v) begin
      m_samp.push_back(d);
      if (m_samp.size() == DECIM) begin
        s = 0;
        foreach (m_samp[k]) s += m_samp[k];
        q = s / DECIM;
        if ((s % DECIM != 0) && (s < 0)) q -= 1;
        if (q > 127) begin q = 127; m_sat = 1'b1; end
        if (q < -128) begin q = -128; m_sat = 1'b1; end
        m_samp.delete();
        if (m_fifo.size() == DEPTH && !pop) m_ovf = 1'b1;
        else push = 1'b1;
      end
    end
    if (pop)  void'(m_fifo.pop_front());
    if (push) m_fifo.push_back(q);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, 32'(o_valid), (m_fifo.size() > 0) ? 1 : 0);
    check({tag, ".data"}, 32'(o_data), (m_fifo.size() > 0) ? m_fifo[0] : 0);
    check({tag, ".level"}, 32'(o_level), m_fifo.size());
    check({tag, ".sat"}, 32'(o_sat), 32'(m_sat));
    check({tag, ".ovf"}, 32'(o_overflow), 32'(m_ovf));
  endtask

  // Called on a falling edge: apply inputs, let one rising edge pass, check.
  task automatic cycle(input string tag, input bit v, input int d, input bit r, input bit c);
    i_valid = v;
    i_data  = NB_IN'(d);
    i_ready = r;
    i_clear = c;
    model_step(v, d, r, c);
    @(negedge i_clock);
    check_outputs(tag);
  endtask

  task automatic dump_value(input string tag, input int val, input bit r);
    for (int k = 0; k < DECIM; k++) cycle(tag, 1'b1, val, r, 1'b0);
  endtask

  initial begin
    i_reset_n = 1'b0;
    i_data    = '0;
    i_valid   = 1'b0;
    i_clear   = 1'b0;
    i_ready   = 1'b0;
    model_reset();
    @(negedge i_clock);
    @(negedge i_clock);
    check_outputs("reset");
    i_reset_n = 1'b1;

    // Constant 10: one averaged output per four samples, one cycle after the dump.
    for (int k = 0; k < 12; k++) cycle("const10", 1'b1, 10, 1'b1, 1'b0);
    cycle("const10.idle", 1'b0, 0, 1'b1, 1'b0);

    // Saturation high and low; the flag sticks until clear.
    dump_value("sat_hi", 300, 1'b1);
    check("sat_hi.value", 32'(o_data), 127);
    dump_value("sat_lo", -1024, 1'b1);
    check("sat_lo.value", 32'(o_data), -128);
    for (int k = 0; k < 3; k++) cycle("sat.hold", 1'b0, 0, 1'b1, 1'b0);
    check("sat.sticky", 32'(o_sat), 1);
    cycle("sat.clear", 1'b0, 0, 1'b1, 1'b1);

    // Floor rounding with stalls between samples.
    foreach (m_samp[k]) m_samp.delete();
    begin
      int vals[4] = '{-1, 0, 0, 0};
      for (int k = 0; k < 4; k++) begin
        cycle("floor", 1'b1, vals[k], 1'b0, 1'b0);
        for (int g = 0; g < 3; g++) cycle("floor.gap", 1'b0, 77, 1'b0, 1'b0);
      end
    end
    check("floor.value", 32'(o_data), -1);
    cycle("floor.pop", 1'b0, 0, 1'b1, 1'b0);

    // Backpressure: five dumps into a four-entry FIFO, then drain.
    for (int v = 1; v <= 5; v++) dump_value("bp.fill", v, 1'b0);
    check("bp.level", 32'(o_level), 4);
    check("bp.ovf", 32'(o_overflow), 1);
    for (int k = 0; k < 6; k++) cycle("bp.drain", 1'b0, 0, 1'b1, 1'b0);
    cycle("bp.clear", 1'b0, 0, 1'b0, 1'b1);

    // Full FIFO with a dump coinciding with a pop.
    for (int v = 11; v <= 14; v++) dump_value("fp.fill", v, 1'b0);
    for (int k = 0; k < 3; k++) cycle("fp.acc", 1'b1, 20, 1'b0, 1'b0);
    cycle("fp.dump_pop", 1'b1, 20, 1'b1, 1'b0);
    check("fp.level", 32'(o_level), 4);
    check("fp.ovf", 32'(o_overflow), 0);
    for (int k = 0; k < 6; k++) cycle("fp.drain", 1'b0, 0, 1'b1, 1'b0);

    // Clear mid-accumulation discards the partial sum and that cycle's sample.
    cycle("clr.acc", 1'b1, 50, 1'b1, 1'b0);
    cycle("clr.acc", 1'b1, 50, 1'b1, 1'b0);
    cycle("clr.pulse", 1'b1, 99, 1'b1, 1'b1);
    dump_value("clr.after", 8, 1'b0);
    check("clr.value", 32'(o_data), 8);
    cycle("clr.pop", 1'b0, 0, 1'b1, 1'b0);

    // Random traffic, occasional clear.
    for (int k = 0; k < 400; k++) begin
      cycle("rand", ($urandom_range(0, 3) != 0), int'($urandom_range(0, 2047)) - 1024,
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 99) == 0));
    end

    // Asynchronous reset with FIFO non-empty and flags set.
    cycle("ar.clear", 1'b0, 0, 1'b0, 1'b1);
    dump_value("ar.fill", 500, 1'b0);
    dump_value("ar.fill", 3, 1'b0);
    check("ar.pre_level", 32'(o_level), 2);
    #2;
    i_reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge i_clock);
    i_reset_n = 1'b1;
    cycle("ar.after", 1'b0, 0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
